// File: rtl/rv32_e_seq_divider.sv
//------------------------------------------------------------------------------
// Module      : rv32_e_seq_divider
// Description : Multi-cycle radix-2 restoring divider for RV32M
//               DIV/DIVU/REM/REMU. It produces one quotient bit per cycle and
//               returns the quotient and remainder with a one-cycle done pulse.
//               Optional macro RV32_DIV_EARLY_OUT_EN: when it is defined,
//               divide-by-zero, signed overflow and |divisor| > |dividend|
//               complete with a short latency instead of the full one.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module rv32_e_seq_divider #(
  parameter int XLEN = 32
) (
  input  logic            clk_i,
  input  logic            rst_n_i,
  input  logic            start_i,
  input  logic            signed_i,
  input  logic [XLEN-1:0] dividend_i,
  input  logic [XLEN-1:0] divisor_i,
  output logic            busy_o,
  output logic            done_o,
  output logic [XLEN-1:0] quotient_o,
  output logic [XLEN-1:0] remainder_o
);

  localparam int              c_CNT_W = $clog2(XLEN);
  localparam logic [XLEN-1:0] c_ONE   = {{(XLEN-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t             r_state;
  logic [c_CNT_W-1:0] r_cnt;
  logic [XLEN-1:0]    r_rem;   // partial remainder
  logic [XLEN-1:0]    r_dq;    // dividend shifting out, quotient shifting in
  logic [XLEN-1:0]    r_dvs;   // divisor magnitude
  logic               r_qneg;
  logic               r_rneg;
  logic               r_div0;

  // Operand magnitudes and signs seen at accept time
  logic            w_dvd_neg;
  logic            w_dvs_neg;
  logic [XLEN-1:0] w_dvd_mag;
  logic [XLEN-1:0] w_dvs_mag;
  logic            w_div0;

  assign w_dvd_neg = signed_i & dividend_i[XLEN-1];
  assign w_dvs_neg = signed_i & divisor_i[XLEN-1];
  assign w_dvd_mag = w_dvd_neg ? (~dividend_i + c_ONE) : dividend_i;
  assign w_dvs_mag = w_dvs_neg ? (~divisor_i + c_ONE) : divisor_i;
  assign w_div0    = (divisor_i == '0);

  // One restoring step: the shifted remainder keeps its top bit in an
  // XLEN+1-bit value so large unsigned divisors are handled correctly.
  logic [XLEN:0] w_part;
  logic [XLEN:0] w_diff;
  logic          w_fit;

  assign w_part = {r_rem, r_dq[XLEN-1]};
  assign w_diff = w_part - {1'b0, r_dvs};
  assign w_fit  = ~w_diff[XLEN];

  // Sign correction; divide-by-zero forces an all-ones quotient while the
  // remainder path naturally reproduces the dividend.
  logic [XLEN-1:0] w_q_fix;
  logic [XLEN-1:0] w_r_fix;

  assign w_q_fix = r_div0 ? '1 : (r_qneg ? (~r_dq + c_ONE) : r_dq);
  assign w_r_fix = r_rneg ? (~r_rem + c_ONE) : r_rem;

`ifdef RV32_DIV_EARLY_OUT_EN
  // Trivial cases whose result is known directly from the operands
  logic            w_ovf;
  logic            w_early;
  logic [XLEN-1:0] w_early_q;
  logic [XLEN-1:0] w_early_r;

  assign w_ovf     = signed_i & (dividend_i == {1'b1, {(XLEN-1){1'b0}}}) &
                     (divisor_i == '1);
  assign w_early   = w_div0 | w_ovf | (w_dvs_mag > w_dvd_mag);
  assign w_early_q = w_div0 ? '1 : (w_ovf ? dividend_i : '0);
  assign w_early_r = w_ovf ? '0 : dividend_i;
`endif

  // Control FSM with datapath and registered outputs
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_rem       <= '0;
      r_dq        <= '0;
      r_dvs       <= '0;
      r_qneg      <= 1'b0;
      r_rneg      <= 1'b0;
      r_div0      <= 1'b0;
      busy_o      <= 1'b0;
      done_o      <= 1'b0;
      quotient_o  <= '0;
      remainder_o <= '0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          done_o <= 1'b0;
          if (start_i) begin
            busy_o <= 1'b1;
`ifdef RV32_DIV_EARLY_OUT_EN
            // Early results pass through FIX unchanged (signs cleared)
            if (w_early) begin
              r_rem   <= w_early_r;
              r_dq    <= w_early_q;
              r_dvs   <= '0;
              r_qneg  <= 1'b0;
              r_rneg  <= 1'b0;
              r_div0  <= 1'b0;
              r_cnt   <= '0;
              r_state <= S_FIX;
            end else
`endif
            begin
              r_rem   <= '0;
              r_dq    <= w_dvd_mag;
              r_dvs   <= w_dvs_mag;
              r_qneg  <= w_dvd_neg ^ w_dvs_neg;
              r_rneg  <= w_dvd_neg;
              r_div0  <= w_div0;
              r_cnt   <= c_CNT_W'(XLEN - 1);
              r_state <= S_CALC;
            end
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_CALC: begin
          r_rem <= w_fit ? w_diff[XLEN-1:0] : w_part[XLEN-1:0];
          r_dq  <= {r_dq[XLEN-2:0], w_fit};
          if (r_cnt == '0) begin
            r_state <= S_FIX;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        S_FIX: begin
          quotient_o  <= w_q_fix;
          remainder_o <= w_r_fix;
          busy_o      <= 1'b0;
          done_o      <= 1'b1;
          r_state     <= S_DONE;
        end
        default: begin
          r_state <= S_IDLE;
          busy_o  <= 1'b0;
          done_o  <= 1'b0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire
